// File: rtl/reqrsp_pkg.sv
// reqrsp_pkg: shared request/response types and AMO opcode helpers.
package reqrsp_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    function automatic logic is_amo(amo_op_e op);
        return op inside {AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor, AMOMax, AMOMaxu, AMOMin, AMOMinu};
    endfunction

    // Codes 0xC-0xF are reserved and answered with an error response.
    function automatic logic is_err(amo_op_e op);
        logic [3:0] v;
        v = op;
        return v >= 4'hC;
    endfunction
endpackage

// File: rtl/reqrsp_amo_alu.sv
// reqrsp_amo_alu: combinational read-modify-write operator for 32-bit AMOs.
module reqrsp_amo_alu
    import reqrsp_pkg::*;
(
    input  amo_op_e     op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] data_i,
    output logic [31:0] new_o
);
    always_comb begin
        case (op_i)
            AMOAdd:  new_o = old_i + data_i;
            AMOAnd:  new_o = old_i & data_i;
            AMOOr:   new_o = old_i | data_i;
            AMOXor:  new_o = old_i ^ data_i;
            AMOMax:  new_o = ($signed(old_i) > $signed(data_i)) ? old_i : data_i;
            AMOMaxu: new_o = (old_i > data_i) ? old_i : data_i;
            AMOMin:  new_o = ($signed(old_i) < $signed(data_i)) ? old_i : data_i;
            AMOMinu: new_o = (old_i < data_i) ? old_i : data_i;
            default: new_o = data_i;
        endcase
    end
endmodule

// File: rtl/reqrsp_amo_sequencer.sv
// reqrsp_amo_sequencer: single-outstanding request sequencer turning loads, stores,
// AMOs and LR/SC into read/write memory accesses with one reservation slot.
module reqrsp_amo_sequencer
    import reqrsp_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_data_i,
    input  logic [3:0]           req_strb_i,
    input  amo_op_e              req_amo_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_error_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i
);
    typedef enum logic [2:0] {Idle, RdReq, RdWait, WrReq, WrWait, Respond} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d, old_q, old_d, amo_new;
    logic [3:0]           strb_q, strb_d;
    amo_op_e              amo_q, amo_d;
    logic [IdWidth-1:0]   id_q, id_d, rsv_id_q, rsv_id_d;
    logic                 err_q, err_d, rsv_valid_q, rsv_valid_d, sc_hit;
    logic [AddrWidth-3:0] rsv_addr_q, rsv_addr_d;

    reqrsp_amo_alu i_alu (.op_i(amo_q), .old_i(old_q), .data_i(data_q), .new_o(amo_new));

    assign sc_hit = rsv_valid_q && rsv_id_q == req_id_i && rsv_addr_q == req_addr_i[AddrWidth-1:2];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        amo_d       = amo_q;
        id_d        = id_q;
        old_d       = old_q;
        err_d       = err_q;
        rsv_valid_d = rsv_valid_q;
        rsv_id_d    = rsv_id_q;
        rsv_addr_d  = rsv_addr_q;
        case (state_q)
            Idle: if (req_valid_i) begin
                addr_d = req_addr_i;
                data_d = req_data_i;
                strb_d = req_strb_i;
                amo_d  = req_amo_i;
                id_d   = req_id_i;
                old_d  = '0;
                err_d  = 1'b0;
                if (is_err(req_amo_i)) begin
                    err_d   = 1'b1;
                    state_d = Respond;
                end else if (req_amo_i == AMOSC) begin
                    rsv_valid_d = 1'b0;
                    old_d       = sc_hit ? 32'd0 : 32'd1;
                    state_d     = sc_hit ? WrReq : Respond;
                end else if (is_amo(req_amo_i) || req_amo_i == AMOLR) begin
                    state_d = RdReq;
                end else begin
                    state_d = req_write_i ? WrReq : RdReq;
                end
            end
            RdReq: state_d = mem_gnt_i ? RdWait : RdReq;
            RdWait: if (mem_rvalid_i) begin
                old_d   = mem_rdata_i;
                state_d = is_amo(amo_q) ? WrReq : Respond;
                if (amo_q == AMOLR) begin
                    rsv_valid_d = 1'b1;
                    rsv_id_d    = id_q;
                    rsv_addr_d  = addr_q[AddrWidth-1:2];
                end
            end
            WrReq: if (mem_gnt_i) begin
                state_d = WrWait;
                if (rsv_addr_q == addr_q[AddrWidth-1:2]) rsv_valid_d = 1'b0;
            end
            WrWait: state_d = mem_rvalid_i ? Respond : WrWait;
            Respond: state_d = rsp_ready_i ? Idle : Respond;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            amo_q       <= AMONone;
            id_q        <= '0;
            old_q       <= '0;
            err_q       <= 1'b0;
            rsv_valid_q <= 1'b0;
            rsv_id_q    <= '0;
            rsv_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            amo_q       <= amo_d;
            id_q        <= id_d;
            old_q       <= old_d;
            err_q       <= err_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_id_q    <= rsv_id_d;
            rsv_addr_q  <= rsv_addr_d;
        end
    end

    assign req_ready_o = state_q == Idle;
    assign rsp_valid_o = state_q == Respond;
    assign rsp_data_o  = old_q;
    assign rsp_error_o = err_q;
    assign rsp_id_o    = id_q;
    assign mem_req_o   = state_q == RdReq || state_q == WrReq;
    assign mem_we_o    = state_q == WrReq;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = mem_we_o ? (is_amo(amo_q) ? amo_new : data_q) : '0;
    // Only a plain store honours byte strobes; everything else is a full word.
    assign mem_be_o    = (mem_we_o && amo_q == AMONone) ? strb_q : (mem_req_o ? 4'hF : 4'h0);
endmodule

// File: tb/tb_reqrsp_amo_sequencer.sv
// tb_reqrsp_amo_sequencer: directed checks of the AMO sequencer against a small
// zero-wait memory model with hand-computed expectations.
module tb_reqrsp_amo_sequencer;
    import reqrsp_pkg::*;

    logic        clk_i = 0, rst_ni = 0;
    logic        req_valid_i = 0, req_ready_o, req_write_i = 0;
    logic [31:0] req_addr_i = 0, req_data_i = 0;
    logic [3:0]  req_strb_i = 0, req_id_i = 0;
    amo_op_e     req_amo_i = AMONone;
    logic        rsp_valid_o, rsp_ready_i = 1, rsp_error_o;
    logic [31:0] rsp_data_o;
    logic [3:0]  rsp_id_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    logic        gnt_en = 1, stale_rv = 0, rv_q = 0;
    logic [31:0] rd_q = 0;
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0, n_err = 0;

    always #5 clk_i = ~clk_i;

    reqrsp_amo_sequencer #(.AddrWidth(32), .IdWidth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
        .req_amo_i(req_amo_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    assign mem_gnt_i    = gnt_en;
    assign mem_rvalid_i = rv_q | stale_rv;
    assign mem_rdata_i  = stale_rv ? 32'hDEAD_BEEF : rd_q;

    // Memory model: one rvalid the cycle after every granted access.
    always @(posedge clk_i) begin
        rv_q <= mem_req_o && mem_gnt_i;
        if (mem_req_o && mem_gnt_i) begin
            rd_q <= mem[{mem_addr_o[31:2], 2'b00}];
            if (mem_we_o)
                for (int i = 0; i < 4; i++)
                    if (mem_be_o[i]) mem[{mem_addr_o[31:2], 2'b00}][8*i +: 8] = mem_wdata_o[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic wr,
                        input logic [31:0] d, input logic [3:0] sb, input logic [3:0] id,
                        output logic [31:0] rd, output logic er, output logic [3:0] rid,
                        output int lat, output int wrc, output int nreq);
        @(negedge clk_i);
        chk("ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1; req_amo_i = amo_op_e'(op); req_addr_i = a;
        req_write_i = wr; req_data_i = d; req_strb_i = sb; req_id_i = id;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        lat = 1; wrc = 0; nreq = 0;
        while (!rsp_valid_o && lat < 100) begin
            if (mem_req_o) nreq++;
            if (mem_req_o && mem_we_o && wrc == 0) wrc = lat;
            @(posedge clk_i); #1;
            lat++;
        end
        rd = rsp_data_o; er = rsp_error_o; rid = rsp_id_o;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [3:0]  rid;
        int          lat, wrc, nreq;
        mem[32'h40]  = 32'h1234_5678;
        mem[32'h100] = 32'hFFFF_FFFF;
        mem[32'h104] = 32'h8000_0000;
        mem[32'h108] = 32'h8000_0000;
        mem[32'h10C] = 32'hF0F0_F0F0;
        mem[32'h110] = 32'h0000_0005;
        mem[32'h114] = 32'h0000_0005;
        mem[32'h118] = 32'h0F0F_0F0F;
        mem[32'h200] = 32'h0000_0011;
        mem[32'h300] = 32'h0000_0000;
        mem[32'h400] = 32'h0000_0005;
        #12;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        @(negedge clk_i) rst_ni = 1;

        xact(AMONone, 32'h40, 0, 0, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("load_data", rd, 32'h1234_5678);
        chk("load_lat", lat, 3);
        chk("load_id", {28'd0, rid}, 32'd1);
        chk("load_err", {31'd0, er}, 32'd0);

        xact(AMONone, 32'h40, 1, 32'hAAAA_BBBB, 4'b0011, 4'd2, rd, er, rid, lat, wrc, nreq);
        chk("store_rsp", rd, 32'd0);
        chk("store_lat", lat, 3);
        chk("store_mem", mem[32'h40], 32'h1234_BBBB);

        xact(AMOAdd, 32'h100, 1, 32'd2, 4'h0, 4'd4, rd, er, rid, lat, wrc, nreq);
        chk("add_rsp", rd, 32'hFFFF_FFFF);
        chk("add_lat", lat, 5);
        chk("add_wr_cycle", wrc, 3);
        chk("add_mem", mem[32'h100], 32'h0000_0001);

        xact(AMOMax, 32'h104, 1, 32'd1, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("max_rsp", rd, 32'h8000_0000);
        chk("max_mem", mem[32'h104], 32'h0000_0001);
        xact(AMOMaxu, 32'h108, 1, 32'd1, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("maxu_mem", mem[32'h108], 32'h8000_0000);
        xact(AMOAnd, 32'h10C, 1, 32'hFF00_FF00, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("and_mem", mem[32'h10C], 32'hF000_F000);
        xact(AMOMinu, 32'h110, 1, 32'hFFFF_FFFF, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("minu_mem", mem[32'h110], 32'h0000_0005);
        xact(AMOMin, 32'h114, 1, 32'hFFFF_FFFF, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("min_mem", mem[32'h114], 32'hFFFF_FFFF);
        xact(AMOXor, 32'h118, 1, 32'hFFFF_0000, 4'h0, 4'd1, rd, er, rid, lat, wrc, nreq);
        chk("xor_mem", mem[32'h118], 32'hF0F0_0F0F);

        xact(AMOLR, 32'h200, 0, 0, 4'h0, 4'd3, rd, er, rid, lat, wrc, nreq);
        chk("lr_data", rd, 32'h11);
        xact(AMOSC, 32'h200, 1, 32'hAB, 4'h0, 4'd3, rd, er, rid, lat, wrc, nreq);
        chk("sc_ok_rsp", rd, 32'd0);
        chk("sc_ok_mem", mem[32'h200], 32'hAB);
        xact(AMOSC, 32'h200, 1, 32'hCD, 4'h0, 4'd3, rd, er, rid, lat, wrc, nreq);
        chk("sc2_rsp", rd, 32'd1);
        chk("sc2_lat", lat, 1);
        chk("sc2_mem", mem[32'h200], 32'hAB);

        xact(AMOLR, 32'h200, 0, 0, 4'h0, 4'd3, rd, er, rid, lat, wrc, nreq);
        xact(AMONone, 32'h200, 1, 32'h77, 4'hF, 4'd5, rd, er, rid, lat, wrc, nreq);
        xact(AMOSC, 32'h200, 1, 32'h99, 4'h0, 4'd3, rd, er, rid, lat, wrc, nreq);
        chk("kill_sc_rsp", rd, 32'd1);
        chk("kill_sc_nreq", nreq, 0);
        chk("kill_mem", mem[32'h200], 32'h77);

        xact(4'hC, 32'h40, 0, 32'h55, 4'h0, 4'd6, rd, er, rid, lat, wrc, nreq);
        chk("err_flag", {31'd0, er}, 32'd1);
        chk("err_data", rd, 32'd0);
        chk("err_lat", lat, 1);
        chk("err_nreq", nreq, 0);
        chk("err_id", {28'd0, rid}, 32'd6);

        // Backpressure: grant withheld for 4 cycles, response stalled for 3.
        gnt_en = 0; rsp_ready_i = 0;
        @(negedge clk_i);
        req_valid_i = 1; req_amo_i = AMONone; req_addr_i = 32'h300; req_write_i = 1;
        req_data_i = 32'hCAFE_F00D; req_strb_i = 4'b1100; req_id_i = 4'd7;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_mem_req", {31'd0, mem_req_o}, 32'd1);
            chk("bp_mem_addr", mem_addr_o, 32'h300);
            chk("bp_mem_wdata", mem_wdata_o, 32'hCAFE_F00D);
            chk("bp_mem_be", {28'd0, mem_be_o}, 32'hC);
            chk("bp_mem_we", {31'd0, mem_we_o}, 32'd1);
            chk("bp_ready_mem", {31'd0, req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        gnt_en = 1;
        lat = 0;
        while (!rsp_valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
        chk("bp_rsp_reached", {31'd0, rsp_valid_o}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_rsp_data", rsp_data_o, 32'd0);
            chk("bp_rsp_id", {28'd0, rsp_id_o}, 32'd7);
            chk("bp_ready_rsp", {31'd0, req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 1;
        @(posedge clk_i); #1;
        chk("bp_done_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("bp_done_ready", {31'd0, req_ready_o}, 32'd1);
        chk("bp_mem", mem[32'h300], 32'hCAFE_0000);

        // Reset while the AMO write is outstanding in WrWait.
        @(negedge clk_i);
        req_valid_i = 1; req_amo_i = AMOSwap; req_addr_i = 32'h400; req_write_i = 1;
        req_data_i = 32'h66; req_strb_i = 4'h0; req_id_i = 4'd8;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        repeat (3) begin @(posedge clk_i); #1; end
        chk("rw_in_wrwait_req", {31'd0, mem_req_o}, 32'd0);
        rst_ni = 0; #1;
        chk("rw_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rw_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rw_rst_addr", mem_addr_o, 32'd0);
        @(negedge clk_i) rst_ni = 1;
        @(negedge clk_i) stale_rv = 1;
        @(negedge clk_i) stale_rv = 0;
        chk("rw_stale_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rw_stale_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rw_swap_mem", mem[32'h400], 32'h66);
        xact(AMONone, 32'h400, 0, 0, 4'h0, 4'd2, rd, er, rid, lat, wrc, nreq);
        chk("rw_load_data", rd, 32'h66);
        chk("rw_load_lat", lat, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reqrsp_amo_sequencer.md
REQRSP_AMO_SEQUENCER -- requirements
Module: reqrsp_amo_sequencer

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, byte address width.
REQ-002 SHALL have parameter IdWidth, default 4, requester ID width; data width is fixed at 32 bits.
REQ-003 SHALL have ports: clk_i in 1, the single clock; rst_ni in 1, asynchronous active-low reset.
REQ-004 SHALL have request ports: req_valid_i in 1; req_ready_o out 1; req_addr_i in AddrWidth; req_write_i in 1; req_data_i in 32; req_strb_i in 4; req_amo_i in amo_op_e; req_id_i in IdWidth.
REQ-005 SHALL have response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_data_o out 32; rsp_error_o out 1; rsp_id_o out IdWidth.
REQ-006 SHALL have memory ports: mem_req_o out 1; mem_gnt_i in 1; mem_addr_o out AddrWidth; mem_we_o out 1; mem_wdata_o out 32; mem_be_o out 4; mem_rvalid_i in 1; mem_rdata_i in 32.

Function
REQ-007 SHALL hold one transaction at a time; req_ready_o = 1 only in state Idle.
REQ-008 SHALL use FSM states Idle, RdReq, RdWait, WrReq, WrWait, Respond.
REQ-009 Idle, on req_valid_i: register the request; load (AMONone, !write) or LR -> RdReq; store (AMONone, write) -> WrReq; AMO op -> RdReq; SC with matching reservation -> WrReq; SC without match -> Respond with rsp_data_o = 1.
REQ-010 SHALL respond to amo codes 0xC-0xF directly from Idle -> Respond with rsp_error_o = 1, rsp_data_o = 0, no memory access.
REQ-011 SHALL hold mem_req_o and all mem_* outputs stable from assertion until the mem_gnt_i cycle; RdReq -> RdWait and WrReq -> WrWait on grant.
REQ-012 SHALL treat every granted access, reads and writes, as returning exactly one mem_rvalid_i; mem_rvalid_i is consumed only in RdWait/WrWait and ignored elsewhere.
REQ-013 RdWait on mem_rvalid_i: capture mem_rdata_i as old; AMO -> WrReq; load/LR -> Respond.
REQ-014 WrWait on mem_rvalid_i -> Respond.
REQ-015 SHALL write new = f(old, req_data) for AMOs: Swap = data; Add = old+data mod 2^32; And/Or/Xor bitwise; Max/Min signed 32-bit; Maxu/Minu unsigned; And uses true AND, with no operand inversion.
REQ-016 AMO, LR, and SC SHALL drive mem_be_o = 4'hF and ignore req_strb_i; plain store drives req_strb_i; reads drive 4'hF.
REQ-017 SHALL return response data as follows: load/LR/AMO return old; store returns 0; SC success 0, fail 1; rsp_id_o = registered req_id_i.
REQ-018 In Respond, SHALL hold rsp_valid_o = 1 with stable payload until rsp_ready_i; the handshake cycle -> Idle; no new request is accepted in that cycle.
REQ-019 SHALL keep a single reservation {valid, id, word addr[AddrWidth-1:2]}; LR sets it at rvalid.
REQ-020 SC SHALL always clear the reservation, at Idle decode.
REQ-021 Any store or AMO write granted to the reserved word, from any ID, SHALL clear the reservation at the grant cycle.
REQ-022 SHALL meet cycle latencies with zero-wait grant and 1-cycle rvalid, acceptance at cycle 0: load rsp_valid_o at cycle 3; AMO write request at cycle 3, rsp_valid_o at cycle 5; SC fail rsp_valid_o at cycle 1.

Reset
REQ-023 rst_ni low SHALL asynchronously force Idle, clear the reservation, and drive mem_req_o, mem_we_o, rsp_valid_o, and rsp_error_o to 0 and all data/address outputs to 0.
REQ-024 Reset mid-operation SHALL abandon the transaction; stale mem_rvalid_i after reset is ignored per REQ-012.

Structure
REQ-025 amo_op_e SHALL be taken from reqrsp_pkg, and is_amo SHALL be reused for the REQ-009 decode; the FSM state enum SHALL stay local.
REQ-026 SHALL place the REQ-015 combinational operator in sub-module reqrsp_amo_alu (inputs op, old, data; output new).

Verification
REQ-027 The bench SHALL cover AMOAdd: mem[0x100] = 0xFFFFFFFF, data = 2 -> mem[0x100] = 0x00000001, rsp_data_o = 0xFFFFFFFF, rsp_valid_o at cycle 5.
REQ-028 The bench SHALL cover AMOMax vs AMOMaxu: old = 0x80000000, data = 1 -> Max writes 0x00000001; Maxu writes 0x80000000.
REQ-029 The bench SHALL cover LR/SC: LR 0x200 id 3, then SC 0x200 id 3 data 0xAB -> rsp 0, mem = 0xAB; a second SC -> rsp 1, memory unchanged.
REQ-030 The bench SHALL cover reservation kill: LR 0x200 id 3, store 0x200 id 5, SC id 3 -> rsp 1 with no mem_req_o.
REQ-031 The bench SHALL cover backpressure: mem_gnt_i low 4 cycles and rsp_ready_i low 3 cycles -> mem_* and rsp_* remain stable and req_ready_o remains 0 throughout.
REQ-032 The bench SHALL cover reset in WrWait during an AMO, then a load -> Idle after reset, a stale rvalid ignored, the load returns the correct data.
